// File: rtl/ex_wb_skid_pkg.sv
// Shared core definitions for the EX-to-WB result path.
package ex_wb_skid_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO       = 0;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      we;
    logic [XLEN_DEF-1:0]       data;
  } result_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_wb_skid_fwd_match.sv
// Forwarding lookup of one source index against the OUT and SKID entries.
module fwd_match
  import ex_wb_skid_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  out_valid,
  input  logic [REG_ADDR_W-1:0] out_rd,
  input  logic                  out_we,
  input  logic [XLEN-1:0]       out_data,
  input  logic                  skid_valid,
  input  logic [REG_ADDR_W-1:0] skid_rd,
  input  logic                  skid_we,
  input  logic [XLEN-1:0]       skid_data,
  input  logic [REG_ADDR_W-1:0] rs,
  output logic                  hit,
  output logic [XLEN-1:0]       data
);

  logic out_hit;
  logic skid_hit;

  always_comb begin
    out_hit  = out_valid && out_we && (out_rd != REG_ADDR_W'(REG_ZERO)) && (out_rd == rs);
    skid_hit = skid_valid && skid_we && (skid_rd != REG_ADDR_W'(REG_ZERO)) && (skid_rd == rs);
    hit      = out_hit || skid_hit;
    // SKID holds the younger result, so it shadows OUT
    if (skid_hit) begin
      data = skid_data;
    end else if (out_hit) begin
      data = out_data;
    end else begin
      data = '0;
    end
  end

endmodule

// File: rtl/ex_wb_skid.sv
// EX-to-WB result stage: 2-entry skid buffer toward WB plus forwarding lookup for ID.
module ex_wb_skid
  import ex_wb_skid_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_we_i,
  input  logic [XLEN-1:0]       ex_result_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  wb_we_o,
  output logic [XLEN-1:0]       wb_result_o,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  output logic                  fwd_rs1_hit_o,
  output logic                  fwd_rs2_hit_o,
  output logic [XLEN-1:0]       fwd_rs1_data_o,
  output logic [XLEN-1:0]       fwd_rs2_data_o,
  output logic [1:0]            occ_o
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [XLEN-1:0]       data;
  } entry_t;

  skid_state_e state_q, state_n;
  entry_t      out_q, skid_q, ex_in;
  logic        out_v, skid_v;
  logic        ex_fire, wb_fire;
  logic        load_out, load_skid, move_skid;

  assign out_v  = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);
  assign ex_in  = '{rd: ex_rd_i, we: ex_we_i, data: ex_result_i};

  // Ready depends only on registered state so WB back-pressure never reaches EX combinationally
  assign ex_ready_o = !skid_v && !rst;
  assign ex_fire    = ex_valid_i && ex_ready_o;
  assign wb_fire    = out_v && wb_ready_i;

  always_comb begin
    state_n   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (ex_fire) begin
            state_n  = ONE;
            load_out = 1'b1;
          end
        end
        ONE: begin
          if (ex_fire && wb_fire) begin
            load_out = 1'b1;
          end else if (wb_fire) begin
            state_n = EMPTY;
          end else if (ex_fire) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: begin
          if (wb_fire) begin
            state_n   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_n;
      if (load_out) begin
        out_q <= ex_in;
      end else if (move_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= ex_in;
      end
    end
  end

  assign wb_valid_o  = out_v;
  assign wb_rd_o     = out_v ? out_q.rd   : '0;
  assign wb_we_o     = out_v ? out_q.we   : 1'b0;
  assign wb_result_o = out_v ? out_q.data : '0;
  assign occ_o       = {1'b0, out_v} + {1'b0, skid_v};

  fwd_match #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .out_valid  (out_v),
    .out_rd     (out_q.rd),
    .out_we     (out_q.we),
    .out_data   (out_q.data),
    .skid_valid (skid_v),
    .skid_rd    (skid_q.rd),
    .skid_we    (skid_q.we),
    .skid_data  (skid_q.data),
    .rs         (id_rs1_i),
    .hit        (fwd_rs1_hit_o),
    .data       (fwd_rs1_data_o)
  );

  fwd_match #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .out_valid  (out_v),
    .out_rd     (out_q.rd),
    .out_we     (out_q.we),
    .out_data   (out_q.data),
    .skid_valid (skid_v),
    .skid_rd    (skid_q.rd),
    .skid_we    (skid_q.we),
    .skid_data  (skid_q.data),
    .rs         (id_rs2_i),
    .hit        (fwd_rs2_hit_o),
    .data       (fwd_rs2_data_o)
  );

endmodule

// File: tb/tb_ex_wb_skid.sv
// Scoreboard bench for ex_wb_skid: directed stimulus pushes expected WB results, a monitor pops them.
module tb_ex_wb_skid;
  import ex_wb_skid_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_i;
  logic        ex_we_i;
  logic [31:0] ex_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [31:0] wb_result_o;
  logic        flush_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        fwd_rs1_hit_o, fwd_rs2_hit_o;
  logic [31:0] fwd_rs1_data_o, fwd_rs2_data_o;
  logic [1:0]  occ_o;

  int total = 0;
  int bad   = 0;
  result_t exp_q[$];

  always #5 clk = ~clk;

  ex_wb_skid #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .ex_rd_i        (ex_rd_i),
    .ex_we_i        (ex_we_i),
    .ex_result_i    (ex_result_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_rd_o        (wb_rd_o),
    .wb_we_o        (wb_we_o),
    .wb_result_o    (wb_result_o),
    .flush_i        (flush_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .fwd_rs1_hit_o  (fwd_rs1_hit_o),
    .fwd_rs2_hit_o  (fwd_rs2_hit_o),
    .fwd_rs1_data_o (fwd_rs1_data_o),
    .fwd_rs2_data_o (fwd_rs2_data_o),
    .occ_o          (occ_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every WB handshake must deliver the oldest expected result
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1 && wb_ready_i === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no delivery at %0t",
                 wb_rd_o, wb_result_o, $time);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        if (wb_rd_o !== e.rd || wb_we_o !== e.we || wb_result_o !== e.data) begin
          bad++;
          $display("FAIL wb_data: got rd=%0d we=%0b data=%0h expected rd=%0d we=%0b data=%0h at %0t",
                   wb_rd_o, wb_we_o, wb_result_o, e.rd, e.we, e.data, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one result for a cycle; caller guarantees it is accepted
  task automatic send(input logic [4:0] rd, input logic we, input logic [31:0] data);
    result_t r;
    ex_valid_i  = 1'b1;
    ex_rd_i     = rd;
    ex_we_i     = we;
    ex_result_i = data;
    chk("ex_ready_on_send", 64'(ex_ready_o), 64'd1);
    r.rd = rd; r.we = we; r.data = data;
    exp_q.push_back(r);
    step();
    ex_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; ex_rd_i = '0; ex_we_i = 1'b0; ex_result_i = '0;
    wb_ready_i = 1'b0; flush_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0;

    // Reset state
    step(); step();
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("rst_wb_result", 64'(wb_result_o), 64'd0);
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready_o), 64'd0);
    chk("rst_fwd1", 64'({fwd_rs1_hit_o, fwd_rs1_data_o}), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ex_ready_o), 64'd1);
    step();

    // Streaming at full rate
    wb_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(5'(i), 1'b1, 32'h11 * 32'(i));
      chk("stream_occ", 64'(occ_o), 64'd1);
      chk("stream_wb_rd", 64'(wb_rd_o), 64'(i));
    end
    step();
    chk("stream_drained_occ", 64'(occ_o), 64'd0);

    // Back-pressure: second result lands in SKID
    wb_ready_i = 1'b0;
    send(5'd5, 1'b1, 32'hA);
    chk("bp_occ1", 64'(occ_o), 64'd1);
    chk("bp_ready1", 64'(ex_ready_o), 64'd1);
    send(5'd6, 1'b1, 32'hB);
    chk("bp_occ2", 64'(occ_o), 64'd2);
    chk("bp_ready0", 64'(ex_ready_o), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_stable_rd", 64'(wb_rd_o), 64'd5);
      chk("bp_stable_data", 64'(wb_result_o), 64'hA);
    end
    wb_ready_i = 1'b1;
    step();
    chk("bp_rel_occ", 64'(occ_o), 64'd1);
    chk("bp_rel_ready", 64'(ex_ready_o), 64'd1);
    chk("bp_rel_data", 64'(wb_result_o), 64'hB);
    step();
    chk("bp_empty", 64'(occ_o), 64'd0);

    // Forwarding priority: SKID shadows OUT
    wb_ready_i = 1'b0;
    send(5'd7, 1'b1, 32'h100);
    send(5'd7, 1'b1, 32'h200);
    id_rs1_i = 5'd7; id_rs2_i = 5'd5;
    #1;
    chk("fwd_pri_hit", 64'(fwd_rs1_hit_o), 64'd1);
    chk("fwd_pri_data", 64'(fwd_rs1_data_o), 64'h200);
    chk("fwd_miss", 64'({fwd_rs2_hit_o, fwd_rs2_data_o}), 64'd0);
    wb_ready_i = 1'b1;
    step();
    chk("fwd_out_only", 64'({fwd_rs1_hit_o, fwd_rs1_data_o}), 64'({1'b1, 32'h200}));
    step();
    chk("fwd_empty", 64'({fwd_rs1_hit_o, fwd_rs1_data_o}), 64'd0);

    // rd = 0 and we = 0 never forward
    wb_ready_i = 1'b0;
    send(5'd0, 1'b1, 32'h55);
    send(5'd8, 1'b0, 32'h66);
    id_rs1_i = 5'd8; id_rs2_i = 5'd0;
    #1;
    chk("fwd_rd0", 64'({fwd_rs2_hit_o, fwd_rs2_data_o}), 64'd0);
    chk("fwd_we0", 64'({fwd_rs1_hit_o, fwd_rs1_data_o}), 64'd0);

    // Flush in FULL: OUT delivered this cycle, SKID and incoming discarded
    flush_i = 1'b1; wb_ready_i = 1'b1;
    ex_valid_i = 1'b1; ex_rd_i = 5'd9; ex_we_i = 1'b1; ex_result_i = 32'h77;
    step();
    void'(exp_q.pop_back());
    flush_i = 1'b0; ex_valid_i = 1'b0;
    chk("flush_occ", 64'(occ_o), 64'd0);
    chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("flush_wb_result", 64'(wb_result_o), 64'd0);
    chk("flush_queue", 64'(exp_q.size()), 64'd0);
    step(); step();

    // Simultaneous accept and drain in ONE
    wb_ready_i = 1'b0;
    send(5'd1, 1'b1, 32'h1);
    wb_ready_i = 1'b1;
    send(5'd2, 1'b1, 32'h2);
    chk("sim_occ", 64'(occ_o), 64'd1);
    chk("sim_data", 64'(wb_result_o), 64'h2);
    step();

    // Reset mid-stream with two entries buffered
    wb_ready_i = 1'b0;
    send(5'd3, 1'b1, 32'h3);
    send(5'd4, 1'b1, 32'h4);
    chk("mid_occ2", 64'(occ_o), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ex_ready_o), 64'd0);
    step();
    exp_q.delete();
    id_rs1_i = 5'd4;
    #1;
    chk("mid_rst_occ", 64'(occ_o), 64'd0);
    chk("mid_rst_wb", 64'({wb_valid_o, wb_rd_o, wb_we_o, wb_result_o}), 64'd0);
    chk("mid_rst_fwd", 64'({fwd_rs1_hit_o, fwd_rs1_data_o}), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 64'(ex_ready_o), 64'd1);
    step(); step();

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
